// File: rtl/elevator_dispatcher.sv
// SCAN-order call scheduler: latches panel calls and drives one one-hot floor request at a time.
// Optional MOVE watchdog is built when DISPATCH_TIMEOUT_EN is defined.
module elevator_dispatcher #(
  parameter int FLOORS         = 10,
  parameter int DOOR_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLOORS-1:0] call,
  input  logic [3:0]        Layer,
  output logic [FLOORS-1:0] buttons,
  output logic [FLOORS-1:0] pending,
  output logic              door_open,
  output logic              dir_up,
  output logic              busy,
  output logic              fault
);
  typedef enum logic [1:0] {IDLE, SELECT, MOVE, DOOR} state_t;
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [3:0] TOP = 4'(FLOORS - 1);
  localparam logic [FLOORS-1:0] ONE = {{(FLOORS-1){1'b0}}, 1'b1};

  if (FLOORS < 2 || FLOORS > 16 || DOOR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("elevator_dispatcher: unsupported parameter set");
  end

  state_t            state;
  logic [3:0]        target, layer_c, up_idx, dn_idx, sel_idx;
  logic [DW-1:0]     door_cnt;
  logic [FLOORS-1:0] target_hot, sel_hot, clear, pending_next;
  logic              up_found, dn_found, sel_up, arrived, abandon;

  assign layer_c    = (Layer > TOP) ? TOP : Layer;
  assign target_hot = ONE << target;
  assign arrived    = (Layer == target);

  // Descending scan leaves the lowest hit at/above the car; ascending leaves the highest at/below.
  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_idx   = '0;
    dn_idx   = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && 4'(i) >= layer_c) begin
        up_found = 1'b1;
        up_idx   = 4'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && 4'(i) <= layer_c) begin
        dn_found = 1'b1;
        dn_idx   = 4'(i);
      end
    end
  end

  // Keep sweeping while the current direction has work, otherwise reverse.
  assign sel_up  = dir_up ? up_found : !dn_found;
  assign sel_idx = sel_up ? up_idx : dn_idx;
  assign sel_hot = ONE << sel_idx;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] move_cnt;
  assign abandon = (state == MOVE) && !arrived && (move_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign abandon = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    clear = '0;
    if ((state == MOVE && (arrived || abandon)) || state == DOOR)
      clear = target_hot;
  end

  // The served floor's clear dominates a same-edge call for it.
  assign pending_next = (pending | call) & ~clear;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      target    <= '0;
      door_cnt  <= '0;
      buttons   <= '0;
      pending   <= '0;
      door_open <= 1'b0;
      dir_up    <= 1'b1;
      busy      <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      move_cnt  <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      pending <= pending_next;
`ifdef DISPATCH_TIMEOUT_EN
      fault   <= abandon;
`endif
      case (state)
        IDLE: begin
          if (|pending) begin
            state <= SELECT;
            busy  <= 1'b1;
          end
        end
        SELECT: begin
          if (!up_found && !dn_found) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= MOVE;
            target  <= sel_idx;
            dir_up  <= sel_up;
            buttons <= sel_hot;
`ifdef DISPATCH_TIMEOUT_EN
            move_cnt <= '0;
`endif
          end
        end
        MOVE: begin
          if (arrived) begin
            buttons   <= '0;
            door_open <= 1'b1;
            door_cnt  <= DW'(DOOR_CYCLES);
            state     <= DOOR;
          end else if (abandon) begin
            buttons <= '0;
            state   <= (|pending_next) ? SELECT : IDLE;
            busy    <= |pending_next;
          end else begin
`ifdef DISPATCH_TIMEOUT_EN
            move_cnt <= move_cnt + 1'b1;
`endif
          end
        end
        DOOR: begin
          if (door_cnt == DW'(1)) begin
            door_open <= 1'b0;
            state     <= (|pending_next) ? SELECT : IDLE;
            busy      <= |pending_next;
          end else begin
            door_cnt <= door_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench for elevator_dispatcher: stimulus queues expected requests and door stops,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_elevator_dispatcher;
  localparam int K_REQ  = 1;
  localparam int K_DOOR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] call = '0;
  logic [3:0] layer = '0;
  logic [9:0] buttons, pending;
  logic       door_open, dir_up, busy, fault;

  typedef struct packed {
    logic [1:0] kind;
    logic [9:0] data;
    logic [3:0] aux;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  elevator_dispatcher #(.FLOORS(10), .DOOR_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .CLK(clk), .RST(rst), .call(call), .Layer(layer), .buttons(buttons),
    .pending(pending), .door_open(door_open), .dir_up(dir_up), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic void push(input int kind, input logic [9:0] data, input int aux);
    exp_t e;
    e.kind = 2'(kind);
    e.data = data;
    e.aux  = 4'(aux);
    exp_q.push_back(e);
  endfunction

  // Monitor: a fresh non-zero request and each falling door_open are transactions.
  logic [9:0] prev_buttons = '0;
  logic       prev_door = 1'b0;
  int         door_len = 0;
  exp_t       got;

  always @(negedge clk) begin
    if (rst) begin
      prev_buttons = '0;
      prev_door    = 1'b0;
      door_len     = 0;
    end else begin
      if (buttons != 10'd0 && buttons != prev_buttons) begin
        if (exp_q.size() == 0) begin
          check("unexpected_request", 32'(buttons), 32'd0);
        end else begin
          got = exp_q.pop_front();
          check("req_kind", K_REQ, 32'(got.kind));
          check("req_buttons", 32'(buttons), 32'(got.data));
          check("req_dir_up", 32'(dir_up), 32'(got.aux));
        end
      end
      if (door_open) begin
        door_len++;
      end else if (prev_door) begin
        if (exp_q.size() == 0) begin
          check("unexpected_door", 32'(pending), 32'hffff);
        end else begin
          got = exp_q.pop_front();
          check("door_kind", K_DOOR, 32'(got.kind));
          check("door_pending", 32'(pending), 32'(got.data));
          check("door_len", 32'(door_len), 32'(got.aux));
        end
        door_len = 0;
      end
      prev_buttons = buttons;
      prev_door    = door_open;
    end
  end

  task automatic wait_buttons(input string name);
    int n = 0;
    while (buttons == 10'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (buttons == 10'd0) expire(name);
  endtask

  task automatic wait_door_done(input string name);
    int n = 0;
    while (!door_open && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (door_open && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) expire(name);
  endtask

  task automatic serve(input int floor, input int travel);
    wait_buttons("serve_wait_request");
    repeat (travel) @(negedge clk);
    layer = 4'(floor);
    wait_door_done("serve_wait_door");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_door_open", 32'(door_open), 32'd0);
    check("rst_dir_up", 32'(dir_up), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single call for floor 2 from floor 0, with exact latency checks.
    call = 10'b0000000100;
    push(K_REQ, 10'h004, 1);
    push(K_DOOR, 10'h000, 4);
    @(negedge clk);
    call = '0;
    check("t1_pending_after_k", 32'(pending), 32'h004);
    check("t1_busy_after_k", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_busy_after_k1", 32'(busy), 32'd1);
    check("t1_buttons_after_k1", 32'(buttons), 32'd0);
    @(negedge clk);
    check("t1_buttons_after_k2", 32'(buttons), 32'h004);
    layer = 4'd2;
    @(negedge clk);
    check("t1_door_after_m", 32'(door_open), 32'd1);
    check("t1_buttons_after_m", 32'(buttons), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_door_after_m3", 32'(door_open), 32'd1);
    @(negedge clk);
    check("t1_door_after_m4", 32'(door_open), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // SCAN order from floor 5 going up with calls {2,7,9}.
    layer = 4'd5;
    call  = 10'b1010000100;
    push(K_REQ, 10'h080, 1);
    push(K_DOOR, 10'h204, 4);
    push(K_REQ, 10'h200, 1);
    push(K_DOOR, 10'h004, 4);
    push(K_REQ, 10'h004, 0);
    push(K_DOOR, 10'h000, 4);
    @(negedge clk);
    call = '0;
    serve(7, 3);
    serve(9, 3);
    serve(2, 3);

    // Zero-travel stop at floor 3.
    layer = 4'd3;
    call  = 10'b0000001000;
    push(K_REQ, 10'h008, 0);
    push(K_DOOR, 10'h000, 4);
    @(negedge clk);
    call = '0;
    repeat (2) @(negedge clk);
    check("t3_buttons_one_cycle", 32'(buttons), 32'h008);
    @(negedge clk);
    check("t3_buttons_dropped", 32'(buttons), 32'd0);
    check("t3_door_open", 32'(door_open), 32'd1);
    wait_door_done("t3_wait_door");

    // Floor 7 held through MOVE and DOOR; floor 4 pressed mid-MOVE must not retarget.
    call = 10'b0010000000;
    push(K_REQ, 10'h080, 1);
    push(K_DOOR, 10'h010, 4);
    push(K_REQ, 10'h010, 0);
    push(K_DOOR, 10'h000, 4);
    wait_buttons("t4_wait_request");
    call = 10'b0010010000;
    @(negedge clk);
    call = 10'b0010000000;
    repeat (2) @(negedge clk);
    layer = 4'd7;
    wait_door_done("t4_wait_door7");
    call = '0;
    serve(4, 2);

    // Asynchronous reset while moving toward floor 5 with {5,9} pending.
    call = 10'b1000100000;
    push(K_REQ, 10'h020, 1);
    @(negedge clk);
    call = '0;
    wait_buttons("t5_wait_request");
    check("t5_pending_before_rst", 32'(pending), 32'h220);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_buttons", 32'(buttons), 32'd0);
    check("t5_rst_pending", 32'(pending), 32'd0);
    check("t5_rst_door_open", 32'(door_open), 32'd0);
    check("t5_rst_dir_up", 32'(dir_up), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_buttons", 32'(buttons), 32'd0);

    // Target 8 with the car never leaving floor 0.
    layer = 4'd0;
    call  = 10'b0100000000;
    push(K_REQ, 10'h100, 1);
    @(negedge clk);
    call = '0;
    wait_buttons("t6_wait_request");
`ifdef DISPATCH_TIMEOUT_EN
    repeat (63) @(negedge clk);
    check("t6_fault_not_yet", 32'(fault), 32'd0);
    check("t6_buttons_still", 32'(buttons), 32'h100);
    @(negedge clk);
    check("t6_fault_pulse", 32'(fault), 32'd1);
    check("t6_buttons_dropped", 32'(buttons), 32'd0);
    check("t6_pending_cleared", 32'(pending), 32'd0);
    @(negedge clk);
    check("t6_fault_one_cycle", 32'(fault), 32'd0);
`else
    repeat (100) @(negedge clk);
    check("t6_buttons_held", 32'(buttons), 32'h100);
    check("t6_fault_low", 32'(fault), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Request scheduler that sits in front of `elevator` and drives its interface: it latches floor calls from a 10-key call panel, serves them in SCAN order, presents one one-hot `buttons` request at a time, and watches the `Layer` floor number for arrival. On arrival it clears the served call and holds a door-open interval before choosing the next target.

## Interface
- `FLOORS`, 10: number of floors. Floors are indexed 0..FLOORS-1; the maximum is 16.
- `DOOR_CYCLES`, 4: number of cycles `door_open` stays high per stop (must be ≥1).
- `TIMEOUT_CYCLES`, 64: MOVE watchdog limit. Used only with `DISPATCH_TIMEOUT_EN`.

Ports:
- `CLK`  in  1: rising-edge clock.
- `RST`  in  1: asynchronous, active-high reset.
- `call`  in  FLOORS: raw call buttons. Level or pulse; any bit high on an edge registers a call.
- `Layer`  in  4: current floor reported by `elevator`.
- `buttons`  out  FLOORS: one-hot request to `elevator`. All zero when no request is active.
- `pending`  out  FLOORS: latched, unserved calls.
- `door_open`  out  1: high during the door interval.
- `dir_up`  out  1: current sweep direction (1 = up).
- `busy`  out  1: high whenever the state is not IDLE.
- `fault`  out  1: one-cycle pulse when the watchdog abandons a target.

## Operation
- Reset values: `buttons`=0, `pending`=0, `door_open`=0, `dir_up`=1, `busy`=0, `fault`=0, target=0, state IDLE.
- `pending` update each edge: `pending <= (pending | call) & ~clear`. `clear` is the one-hot of the floor being served on that edge.
- If a served floor is also called on the same edge, the clear wins (the call is dropped).
- Layer values ≥ FLOORS are clamped to FLOORS-1 for the target search. A clamped value never matches a target.
- State machine:
  - IDLE → SELECT when `pending` is non-zero.
  - SELECT picks the target, then → MOVE.
    - If `dir_up`: target is the lowest pending index ≥ Layer.
    - Else: target is the highest pending index ≤ Layer.
    - If the current direction has no candidate: toggle `dir_up` and search the other direction.
  - MOVE drives `buttons` = one-hot(target) every cycle. Calls that arrive during MOVE only set `pending`; they never retarget the car.
    - When Layer == target: set `buttons` to 0, clear `pending[target]`, set `door_open`=1, load the door counter with DOOR_CYCLES, → DOOR.
  - DOOR holds `door_open`=1 and decrements the counter. New calls for the target floor are cleared every cycle in DOOR.
    - When the counter reaches 1: `door_open`=0, then → SELECT if `pending` is non-zero, else → IDLE.
- A call for the floor the car is already on is served with zero travel: SELECT → MOVE → DOOR on consecutive edges.
- `RST` mid-operation immediately returns every output to its reset value and discards all pending calls.

## Timing
- Call sampled at edge k while IDLE:
  - `pending` bit set after edge k.
  - SELECT after edge k+1.
  - `buttons` valid after edge k+2.
- Arrival: Layer == target sampled at edge m:
  - `buttons`=0 and `door_open`=1 after edge m.
  - `door_open` falls after edge m+DOOR_CYCLES.
  - The next `buttons` request is valid after edge m+DOOR_CYCLES+1 at the earliest.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DISPATCH_TIMEOUT_EN` defined:
  - A MOVE cycle counter counts up from 0 on entry to MOVE.
  - If TIMEOUT_CYCLES cycles pass without arrival: clear `pending[target]`, set `buttons`=0, pulse `fault` for one cycle, then → SELECT if `pending` is non-zero, else → IDLE.
- Not defined: the counter is not built, `fault` is tied 0, and MOVE waits indefinitely.

## Test plan
- Reset, then `call`=10'b0000000100 for 1 cycle with Layer=0 → `buttons`=10'b0000000100 two edges later. Drive Layer=2 → `door_open` high for exactly 4 cycles, `pending`=0, then IDLE with `busy`=0.
- Layer=5, `dir_up`=1, pending floors {2,7,9} → targets served in order 7, 9, then 2. `dir_up` goes 0 when target 2 is selected.
- Layer=3, `call` for floor 3 → zero-travel stop: `buttons` bit 3 high for exactly 1 cycle, then `door_open`.
- Same-edge clear and call: re-press floor 7 continuously during MOVE(7) and DOOR(7) → `pending[7]`=0 when DOOR exits. Floor 4 pressed during MOVE(7) → served after 7 with no retarget.
- `RST` asserted mid-MOVE with `pending`=10'b1000100000 → all outputs at reset values in the same cycle, before the next `CLK` edge. After `RST` deasserts with no calls, the block stays in IDLE.
- With `DISPATCH_TIMEOUT_EN` and TIMEOUT_CYCLES=64: target 8, Layer held at 0 → `fault` pulses after 64 MOVE cycles, `pending[8]`=0, `buttons`=0. Without the macro, `buttons` stays 10'b0100000000 indefinitely.
